// File: rtl/reduce_tree_pipe.sv
// Pipelined bitwise reduction tree with selectable operator and valid/ready
// backpressure; each stage halves the operand and carries its op alongside.

module reduce_tree_stage #(
   parameter  int IN_W   = 2,
   parameter  int LVL    = 0,
   parameter  bit REDUCE = 1'b1,
   localparam int OUT_W  = REDUCE ? IN_W / 2 : IN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             vld_in,
   input  logic [IN_W-1:0]  d_in,
   input  logic [1:0]       op_in,
   output logic             vld_q,
   output logic [OUT_W-1:0] d_q,
   output logic [1:0]       op_q
);
   logic             vld_d;
   logic [OUT_W-1:0] d_d;
   logic [1:0]       op_d;
   logic [OUT_W-1:0] red;

   if (REDUCE) begin : g_red
      localparam int H = IN_W / 2;
      // ALT cycles AND, XOR, OR, XOR over the level index.
      localparam logic [1:0] ALT_OP = (LVL % 4 == 0) ? 2'b00 :
                                      (LVL % 2 == 1) ? 2'b10 : 2'b01;
      logic [H-1:0] hi, lo;
      logic [1:0]   eff;
      always_comb begin
         hi  = d_in[IN_W-1:H];
         lo  = d_in[H-1:0];
         eff = (op_in == 2'b11) ? ALT_OP : op_in;
         case (eff)
            2'b00:   red = hi & lo;
            2'b01:   red = hi | lo;
            default: red = hi ^ lo;
         endcase
      end
   end else begin : g_pass
      assign red = d_in;
   end

   always_comb begin
      vld_d = vld_q;
      d_d   = d_q;
      op_d  = op_q;
      if (ld) begin
         vld_d = vld_in;
         d_d   = red;
         op_d  = op_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= 1'b0;
         d_q   <= '0;
         op_q  <= 2'b00;
      end else begin
         vld_q <= vld_d;
         d_q   <= d_d;
         op_q  <= op_d;
      end
   end
endmodule

module reduce_tree_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_b,
   output logic [1:0]       out_op
);
   localparam int L  = $clog2(WIDTH);
   localparam int DW = 2 * WIDTH - 1;

   // All stage data packed end to end: stage s lives at [2W-2*(W>>s) +: W>>s].
   logic [DW-1:0]     data;
   logic [L:0]        vld;
   logic [L:0][1:0]   op;
   logic [L+1:0]      rdy;

   assign rdy[L+1] = out_ready;

   for (genvar s = 0; s <= L; s++) begin : g_stg
      localparam int SW  = WIDTH >> s;
      localparam int OFF = 2 * WIDTH - 2 * SW;

      // An empty stage always accepts, so bubbles collapse under a stall.
      assign rdy[s] = !vld[s] || rdy[s+1];

      if (s == 0) begin : g_in
         reduce_tree_stage #(.IN_W(WIDTH), .LVL(0), .REDUCE(1'b0)) u_stg (
            .clk    (clk),
            .rst    (rst),
            .ld     (rdy[0]),
            .vld_in (in_valid),
            .d_in   (in_a),
            .op_in  (in_op),
            .vld_q  (vld[0]),
            .d_q    (data[OFF +: SW]),
            .op_q   (op[0])
         );
      end else begin : g_lvl
         localparam int PW   = 2 * SW;
         localparam int POFF = 2 * WIDTH - 2 * PW;
         reduce_tree_stage #(.IN_W(PW), .LVL(s - 1), .REDUCE(1'b1)) u_stg (
            .clk    (clk),
            .rst    (rst),
            .ld     (rdy[s]),
            .vld_in (vld[s-1]),
            .d_in   (data[POFF +: PW]),
            .op_in  (op[s-1]),
            .vld_q  (vld[s]),
            .d_q    (data[OFF +: SW]),
            .op_q   (op[s])
         );
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld[L];
   assign out_b     = data[DW-1];
   assign out_op    = op[L];
endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Scoreboard bench: WIDTH=16 directed/stream/backpressure/bubble/reset tests,
// plus WIDTH=2, 8, 64 instances under random intake with latency checks.

module tb_reduce_tree_pipe;
   typedef struct {
      logic       b;
      logic [1:0] op;
      int         acc;
   } sb_t;

   localparam int W = 16;
   localparam int L = 4;

   logic clk, rst, prst;
   logic in_valid, in_ready, out_valid, out_ready, out_b;
   logic [W-1:0] in_a;
   logic [1:0] in_op, out_op;

   int n_vec = 0, n_err = 0, cyc = 0, n_out = 0;
   bit lat_chk = 1'b1;
   sb_t q[$];

   reduce_tree_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
      .out_b(out_b), .out_op(out_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic model(input logic [63:0] a, input int w, input logic [1:0] op);
      logic [63:0] cur, mask, hi, lo;
      logic [1:0]  e;
      int cw, h, i;
      cur = a; cw = w; i = 0;
      while (cw > 1) begin
         h    = cw / 2;
         mask = (64'd1 << h) - 64'd1;
         hi   = (cur >> h) & mask;
         lo   = cur & mask;
         e    = op;
         if (op == 2'b11) e = (i % 4 == 0) ? 2'b00 : (i % 2 == 1) ? 2'b10 : 2'b01;
         case (e)
            2'b00:   cur = hi & lo;
            2'b01:   cur = hi | lo;
            default: cur = hi ^ lo;
         endcase
         cw = h;
         i++;
      end
      return cur[0];
   endfunction

   // Monitor: push at accept, pop/compare at output transfer, check hold stability.
   bit hold_v = 1'b0;
   logic hold_b;
   logic [1:0] hold_op;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_v = 1'b0;
         end else begin
            if (in_valid && in_ready) begin
               sb_t e;
               e.b = model(64'(in_a), W, in_op); e.op = in_op; e.acc = cyc + 1;
               q.push_back(e);
            end
            if (hold_v) expect_eq("hold", {61'd0, out_valid, out_op, out_b}, {61'd0, 1'b1, hold_op, hold_b});
            if (out_valid) begin
               if (q.size() == 0) expect_eq("spurious_out", 64'(out_valid), 64'd0);
               else if (out_ready) begin
                  sb_t e;
                  e = q.pop_front();
                  n_out++;
                  expect_eq("result", {61'd0, out_op, out_b}, {61'd0, e.op, e.b});
                  if (lat_chk) expect_eq("latency", 64'(cyc - e.acc), 64'(L));
               end
            end
            hold_v  = out_valid && !out_ready;
            hold_b  = out_b;
            hold_op = out_op;
         end
      end
   end

   // Extra widths: random intake, consumer always ready, so latency is exact.
   for (genvar g = 0; g < 3; g++) begin : gp
      localparam int PW = (g == 0) ? 2 : (g == 1) ? 8 : 64;
      localparam int PL = $clog2(PW);
      logic pv, prdy, pov, pb;
      logic [PW-1:0] pa;
      logic [1:0] pio, pop;
      bit done = 1'b0;
      sb_t pq[$];

      reduce_tree_pipe #(.WIDTH(PW)) u_p (
         .clk(clk), .rst(prst), .in_valid(pv), .in_ready(prdy), .in_a(pa),
         .in_op(pio), .out_valid(pov), .out_ready(1'b1), .out_b(pb), .out_op(pop)
      );

      initial begin
         logic [63:0] r;
         pv = 1'b0; pa = '0; pio = 2'b00;
         wait (!prst);
         repeat (300) begin
            @(posedge clk); #1;
            r   = {$urandom, $urandom};
            pv  = 1'($urandom_range(0, 1));
            pa  = r[PW-1:0];
            pio = 2'($urandom_range(0, 3));
         end
         @(posedge clk); #1;
         pv = 1'b0;
         repeat (PL + 3) @(posedge clk);
         #1 expect_eq($sformatf("drain_w%0d", PW), 64'(pq.size()), 64'd0);
         done = 1'b1;
      end

      initial begin
         forever begin
            @(negedge clk);
            if (!prst) begin
               if (pv && prdy) begin
                  sb_t e;
                  e.b = model(64'(pa), PW, pio); e.op = pio; e.acc = cyc + 1;
                  pq.push_back(e);
               end
               if (pov) begin
                  if (pq.size() == 0) expect_eq($sformatf("spurious_w%0d", PW), 64'(pov), 64'd0);
                  else begin
                     sb_t e;
                     e = pq.pop_front();
                     expect_eq($sformatf("result_w%0d", PW), {61'd0, pop, pb}, {61'd0, e.op, e.b});
                     expect_eq($sformatf("latency_w%0d", PW), 64'(cyc - e.acc), 64'(PL));
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, n_err=%0d", n_err);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [1:0] op);
      in_valid = 1'b1; in_a = a; in_op = op;
   endtask

   logic [W-1:0] dir_a [6] = '{16'hFFFF, 16'hFFFE, 16'h0001, 16'h0000, 16'h0101, 16'h00FF};
   logic [1:0]   dir_op[6] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b11, 2'b11};
   logic         dir_b [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      int acc, n0;
      rst = 1'b1; prst = 1'b1;
      in_valid = 1'b0; in_a = '0; in_op = 2'b00; out_ready = 1'b1;
      #1;
      expect_eq("rst_out_valid", 64'(out_valid), 64'd0);
      expect_eq("rst_out_b", 64'(out_b), 64'd0);
      expect_eq("rst_out_op", 64'(out_op), 64'd0);
      expect_eq("rst_in_ready", 64'(in_ready), 64'd1);

      // Golden model self-check against the hand-derived results.
      for (int i = 0; i < 6; i++)
         expect_eq($sformatf("model_dir%0d", i), 64'(model(64'(dir_a[i]), W, dir_op[i])), 64'(dir_b[i]));

      @(posedge clk); #2;
      rst = 1'b0; prst = 1'b0;
      // Directed singles; the first is offered right as reset falls.
      for (int i = 0; i < 6; i++) begin
         drive(dir_a[i], dir_op[i]);
         step();
         in_valid = 1'b0;
         repeat (6) step();
      end
      expect_eq("directed_drain", 64'(q.size()), 64'd0);

      // Back-to-back stream.
      n0 = n_out;
      drive(16'h8000, 2'b01); step();
      drive(16'h8001, 2'b10); step();
      repeat (98) begin
         drive(16'($urandom), 2'($urandom_range(0, 3)));
         step();
      end
      in_valid = 1'b0;
      repeat (6) step();
      expect_eq("stream_count", 64'(n_out - n0), 64'd100);

      // Backpressure: exactly L+1 accepts, then intake resumes with out_ready.
      lat_chk = 1'b0;
      out_ready = 1'b0;
      acc = 0;
      repeat (8) begin
         drive(16'($urandom), 2'($urandom_range(0, 3)));
         if (in_ready) acc++;
         step();
      end
      expect_eq("bp_accepts", 64'(acc), 64'd5);
      expect_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      #1 expect_eq("bp_resume_same_cycle", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      repeat (8) step();
      expect_eq("bp_drain", 64'(q.size()), 64'd0);

      // Bubbles with random consumer stalls.
      for (int i = 0; i < 80; i++) begin
         drive(16'($urandom), 2'($urandom_range(0, 3)));
         in_valid  = 1'(i % 2 == 0);
         out_ready = 1'($urandom_range(0, 1));
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) step();
      expect_eq("bubble_drain", 64'(q.size()), 64'd0);

      // Async reset with three in flight.
      lat_chk = 1'b1;
      repeat (3) begin
         drive(16'hFFFF, 2'b00);
         step();
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      expect_eq("arst_out_valid", 64'(out_valid), 64'd0);
      expect_eq("arst_out_b", 64'(out_b), 64'd0);
      expect_eq("arst_out_op", 64'(out_op), 64'd0);
      expect_eq("arst_in_ready", 64'(in_ready), 64'd1);
      q.delete();
      step();
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         expect_eq("post_rst_no_stale", 64'(out_valid), 64'd0);
      end

      wait (gp[0].done && gp[1].done && gp[2].done);
      @(negedge clk);
      expect_eq("final_drain", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
